// File: rtl/sc_eval_scheduler.sv
// Job controller for the shared stochastic compute datapath: round-robin grant, clear/run/capture sequencing, result handshake.
// Optional abort path is enabled by defining SC_ABORT_EN.
module sc_eval_scheduler #(
  parameter int WIDTH    = 9,
  parameter int WIN_LOG2 = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  input  logic [3:0]           req_op,
  output logic [WIDTH-1:0]     dp_a,
  output logic [WIDTH-1:0]     dp_b,
  output logic [1:0]           dp_op,
  output logic                 dp_clr,
  output logic                 dp_run,
  input  logic [WIN_LOG2:0]    acc_cnt,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data,
  output logic                 res_id,
  output logic                 busy
`ifdef SC_ABORT_EN
  ,
  input  logic                 abort,
  output logic                 abort_ack
`endif
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CAPTURE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [WIN_LOG2-1:0]  cnt_q, cnt_d;
  logic                 ptr_q, ptr_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, data_q, data_d;
  logic [1:0]           op_q, op_d;
  logic                 id_q, id_d;
  logic                 winner, accept, abort_hit;

  // Ones count over a 2^WIN_LOG2 window scaled to WIDTH bits; a full window saturates.
  function automatic logic [WIDTH-1:0] sat_scale(input logic [WIN_LOG2:0] acc);
    if (acc[WIN_LOG2])
      sat_scale = '1;
    else
      sat_scale = WIDTH'(acc >> (WIN_LOG2 - WIDTH));
  endfunction

  always_comb begin
    winner = (req_valid == 2'b11) ? ptr_q : req_valid[1];
    accept = !rst_n && (state_q == IDLE) && (req_valid != 2'b00);
  end

`ifdef SC_ABORT_EN
  logic ack_q;
  assign abort_hit = abort && ((state_q == CLEAR) || (state_q == RUN));
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) ack_q <= 1'b0;
    else       ack_q <= abort_hit;
  end
  assign abort_ack = ack_q;
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    data_d    = data_q;
    id_d      = id_q;
    req_ready = 2'b00;
    dp_clr    = 1'b0;
    dp_run    = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (accept) begin
          req_ready = winner ? 2'b10 : 2'b01;
          a_d       = winner ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
          b_d       = winner ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
          op_d      = winner ? req_op[3:2] : req_op[1:0];
          id_d      = winner;
          ptr_d     = ~winner;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        dp_clr  = 1'b1;
        cnt_d   = '0;
        state_d = abort_hit ? IDLE : RUN;
      end
      RUN: begin
        dp_run = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (abort_hit)
          state_d = IDLE;
        else if (cnt_q == {WIN_LOG2{1'b1}})
          state_d = CAPTURE;
      end
      CAPTURE: begin
        // Accumulator already holds the final RUN cycle here.
        data_d  = sat_scale(acc_cnt);
        state_d = HOLD;
      end
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dp_a     = a_q;
  assign dp_b     = b_q;
  assign dp_op    = op_q;
  assign res_data = data_q;
  assign res_id   = id_q;

endmodule

// File: tb/tb_sc_eval_scheduler.sv
// Self-checking bench for sc_eval_scheduler (WIDTH=4, 64-cycle window).
module tb_sc_eval_scheduler;
  localparam int W   = 4;
  localparam int L   = 6;
  localparam int WIN = 1 << L;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [2*W-1:0] req_a = '0, req_b = '0;
  logic [3:0]   req_op = '0;
  logic [W-1:0] dp_a, dp_b, res_data;
  logic [1:0]   dp_op;
  logic         dp_clr, dp_run, res_valid, res_id, busy;
  logic [L:0]   acc_cnt = '0;
  logic         res_ready = 1'b0;
  logic         abort = 1'b0;
  logic         abort_ack;

  int   checks = 0;
  int   errors = 0;
  logic model_ptr = 1'b0;

  sc_eval_scheduler #(.WIDTH(W), .WIN_LOG2(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
    .dp_clr(dp_clr), .dp_run(dp_run),
    .acc_cnt(acc_cnt),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
`ifdef SC_ABORT_EN
    , .abort(abort), .abort_ack(abort_ack)
`endif
  );

`ifndef SC_ABORT_EN
  assign abort_ack = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Result as a fraction of the window, rescaled to W bits and clamped.
  function automatic int model_data(input int acc);
    if (acc >= WIN) return (1 << W) - 1;
    return (acc * (1 << W)) / WIN;
  endfunction

  typedef struct {
    logic [1:0] v;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] op0, op1;
    int         acc;
    int         stall;
    int         exp_data;
    logic       exp_id;
  } vec_t;

  task automatic run_job(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] b0,
                         input logic [3:0] a1, input logic [3:0] b1,
                         input logic [1:0] op0, input logic [1:0] op1,
                         input int acc, input int stall, input int exp_d, input string nm);
    int k, clr_n, clr_k, run_n, run_k, valid_k;
    logic w, bad;
    logic [3:0] ea, eb;
    logic [1:0] eop;
    req_valid = v; req_a = {a1, a0}; req_b = {b1, b0}; req_op = {op1, op0};
    acc_cnt = (L+1)'(acc); res_ready = 1'b0;
    #1;
    k = 0;
    while (req_ready == 2'b00 && k < 10) begin
      @(negedge clk); #1; k++;
    end
    if (req_ready == 2'b00) begin
      chk({nm, " grant timeout"}, 0, 1);
      return;
    end
    w = (v == 2'b11) ? model_ptr : v[1];
    model_ptr = ~w;
    chk({nm, " req_ready"}, int'(req_ready), w ? 2 : 1);
    ea = w ? a1 : a0; eb = w ? b1 : b0; eop = w ? op1 : op0;
    clr_n = 0; clr_k = -1; run_n = 0; run_k = -1; valid_k = -1; bad = 1'b0;
    for (int c = 1; c <= 200 && valid_k < 0; c++) begin
      @(negedge clk); #1;
      if (dp_clr) begin clr_n++; if (clr_k < 0) clr_k = c; end
      if (dp_run) begin run_n++; if (run_k < 0) run_k = c; end
      if (res_valid) valid_k = c;
      if (!busy || req_ready != 2'b00) bad = 1'b1;
    end
    if (valid_k < 0) begin
      chk({nm, " res_valid timeout"}, 0, 1);
      return;
    end
    chk({nm, " dp_clr cycles"}, clr_n, 1);
    chk({nm, " dp_clr at"}, clr_k, 1);
    chk({nm, " dp_run cycles"}, run_n, WIN);
    chk({nm, " dp_run start"}, run_k, 2);
    chk({nm, " res_valid at"}, valid_k, WIN + 3);
    chk({nm, " busy/ready during job"}, int'(bad), 0);
    chk({nm, " res_data"}, int'(res_data), exp_d);
    chk({nm, " res_id"}, int'(res_id), int'(w));
    chk({nm, " dp_a"}, int'(dp_a), int'(ea));
    chk({nm, " dp_b"}, int'(dp_b), int'(eb));
    chk({nm, " dp_op"}, int'(dp_op), int'(eop));
    if (stall > 0) begin
      bad = 1'b0;
      repeat (stall) begin
        @(negedge clk); #1;
        if (!res_valid || res_data !== 4'(exp_d) || res_id !== w || req_ready != 2'b00 || !busy)
          bad = 1'b1;
      end
      chk({nm, " backpressure hold"}, int'(bad), 0);
    end
    res_ready = 1'b1;
    @(negedge clk); #1;
    res_ready = 1'b0;
    chk({nm, " idle after handshake"}, int'({res_valid, busy}), 0);
    chk({nm, " dp_a kept in idle"}, int'(dp_a), int'(ea));
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{v:2'b01, a0:4'd5, b0:4'd9, a1:4'd0, b1:4'd0, op0:2'b01, op1:2'b00, acc:40, stall:0, exp_data:10, exp_id:1'b0};
    vecs[1] = '{v:2'b10, a0:4'd0, b0:4'd0, a1:4'd3, b1:4'd7, op0:2'b00, op1:2'b10, acc:64, stall:0, exp_data:15, exp_id:1'b1};
    vecs[2] = '{v:2'b01, a0:4'd12, b0:4'd1, a1:4'd2, b1:4'd2, op0:2'b11, op1:2'b01, acc:63, stall:2, exp_data:15, exp_id:1'b0};
    vecs[3] = '{v:2'b01, a0:4'd15, b0:4'd15, a1:4'd4, b1:4'd4, op0:2'b10, op1:2'b00, acc:0, stall:0, exp_data:0, exp_id:1'b0};
    vecs[4] = '{v:2'b10, a0:4'd1, b0:4'd1, a1:4'd6, b1:4'd11, op0:2'b00, op1:2'b01, acc:3, stall:20, exp_data:0, exp_id:1'b1};

    // Reset state, with both requesters asserting.
    req_valid = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    chk("reset req_ready", int'(req_ready), 0);
    chk("reset outputs", int'({dp_a, dp_b, dp_op, res_data, res_id}), 0);
    chk("reset control", int'({dp_clr, dp_run, res_valid, busy, abort_ack}), 0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].v, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
              vecs[i].op0, vecs[i].op1, vecs[i].acc, vecs[i].stall, vecs[i].exp_data,
              $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table id", i), int'(res_id), int'(vecs[i].exp_id));
    end

    // Round-robin: both requesters valid for four jobs, expect ids 0,1,0,1.
    for (int j = 0; j < 4; j++) begin
      run_job(2'b11, 4'd2, 4'd3, 4'd8, 4'd9, 2'b00, 2'b01, 16 * (j + 1), 0,
              model_data(16 * (j + 1)), $sformatf("rr%0d", j));
      chk($sformatf("rr%0d id order", j), int'(res_id), j % 2);
    end

    // Reset in the middle of the window.
    req_valid = 2'b01; req_a = {4'd0, 4'd7}; req_b = {4'd0, 4'd7}; req_op = 4'b0001;
    acc_cnt = 7'd20;
    #1;
    chk("midrst grant", int'(req_ready), 1);
    repeat (32) @(negedge clk);
    #1;
    chk("midrst running", int'(dp_run), 1);
    rst_n = 1'b1;
    #1;
    chk("midrst control", int'({dp_run, busy, res_valid, req_ready}), 0);
    chk("midrst data", int'({dp_a, dp_b, dp_op, res_data, res_id}), 0);
    @(negedge clk);
    rst_n = 1'b0;
    model_ptr = 1'b0;
    run_job(2'b11, 4'd1, 4'd2, 4'd3, 4'd4, 2'b10, 2'b00, 33, 0, model_data(33), "post-reset");
    chk("post-reset winner", int'(res_id), 0);

    // Randomized jobs against the reference model.
    for (int r = 0; r < 20; r++) begin
      logic [1:0] v;
      int acc;
      v   = 2'($urandom_range(1, 3));
      acc = $urandom_range(0, WIN);
      run_job(v, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
              2'($urandom), 2'($urandom), acc, $urandom_range(0, 3),
              model_data(acc), $sformatf("rand%0d", r));
    end

`ifdef SC_ABORT_EN
    begin
      int rv;
      req_valid = 2'b10; req_a = {4'd9, 4'd0}; req_b = {4'd5, 4'd0}; req_op = 4'b0100;
      #1;
      chk("abort grant", int'(req_ready), 2);
      model_ptr = 1'b0;
      repeat (12) @(negedge clk);
      #1;
      chk("abort running", int'(dp_run), 1);
      abort = 1'b1; req_valid = 2'b00;
      @(negedge clk); #1;
      abort = 1'b0;
      chk("abort_ack pulse", int'(abort_ack), 1);
      chk("abort stops run", int'({dp_run, busy}), 0);
      @(negedge clk); #1;
      chk("abort_ack one cycle", int'(abort_ack), 0);
      rv = 0;
      repeat (80) begin
        @(negedge clk); #1;
        if (res_valid || busy) rv = 1;
      end
      chk("abort no result", rv, 0);
      run_job(2'b11, 4'd4, 4'd4, 4'd6, 4'd6, 2'b00, 2'b00, 50, 0, model_data(50), "after-abort");
      chk("after-abort winner", int'(res_id), 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
